uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/uart_rx_sync_2ff.sv | 32 +++
 rtl/uart_rx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver.
// Holds the receive FSM state encoding and the default frame/oversample
// constants used as parameter defaults by uart_rx.
package uart_rx_pkg;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_STOP_TICKS = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // Width needed to count 0..val-1, never less than one bit.
  function automatic int cnt_width(input int val);
    return (val > 1) ? $clog2(val) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk_i   - destination clock
//   reset_i - synchronous active-high reset, forces both flops to RESET_VAL
//   d_i     - asynchronous input
//   q_o     - synchronized output
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage resynchronization chain.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver (LSB first, one start bit, configurable stop).
// Ports:
//   clk         - system clock, all state on rising edge
//   reset       - synchronous active-high reset
//   rx          - asynchronous serial line, idle high
//   tick        - oversample strobe, OVERSAMPLE strobes per bit period
//   dout        - last correctly framed word (FIFO write data)
//   done        - one-clk pulse per good frame (FIFO write)
//   framing_err - one-clk pulse when the stop bit was sampled low
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int STOP_TICKS = DEF_STOP_TICKS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 tick,
  output logic [DATA_BITS-1:0] dout,
  output logic                 done,
  output logic                 framing_err
);

  localparam int SW = cnt_width((OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS);
  localparam int NW = cnt_width(DATA_BITS);

  localparam logic [SW-1:0] S_START_MID = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_BIT_END   = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_MID  = SW'(STOP_TICKS / 2 - 1);
  localparam logic [SW-1:0] S_STOP_END  = SW'(STOP_TICKS - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state_q, state_d;
  logic [SW-1:0]        s_q, s_d;
  logic [NW-1:0]        n_q, n_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 stop_ok_q, stop_ok_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (rx),
    .q_o     (rx_s)
  );

  // State, counters, datapath and output pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      s_q       <= '0;
      n_q       <= '0;
      sh_q      <= '0;
      dout_q    <= '0;
      stop_ok_q <= 1'b0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      sh_q      <= sh_d;
      dout_q    <= dout_d;
      stop_ok_q <= stop_ok_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next-state and frame resolution logic.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    sh_d      = sh_q;
    dout_d    = dout_q;
    stop_ok_d = stop_ok_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Start detection does not wait for a tick, so a start edge seen on
        // the cycle we return here is taken on the very next clk.
        if (!rx_s) begin
          state_d = ST_START;
          s_d     = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick) begin
          if (s_q == S_START_MID) begin
            if (!rx_s) begin
              state_d = ST_DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              // Line went high again before mid-start: treat as a glitch.
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (s_q == S_BIT_END) begin
            s_d  = '0;
            // LSB arrives first, so each new bit enters at the MSB.
            sh_d = DATA_BITS'({rx_s, sh_q} >> 1);
            if (n_q == N_LAST) begin
              state_d = ST_STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (s_q == S_STOP_END) begin
            state_d = ST_IDLE;
            s_d     = '0;
            if (stop_ok_q) begin
              dout_d = sh_q;
              done_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            if (s_q == S_STOP_MID) begin
              stop_ok_d = rx_s;
            end else begin
              stop_ok_d = stop_ok_q;
            end
            s_d = s_q + SW'(1);
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        s_d     = '0;
        n_d     = '0;
      end
    endcase
  end

  assign dout        = dout_q;
  assign done        = done_q;
  assign framing_err = ferr_q;

endmodule
